// File: rtl/mirror_arb_pkg.sv
// Shared types and constants for the register-mirror bus arbiter.
package mirror_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_RESP    = 3'd2,
        ST_WB_ERR  = 3'd3,
        ST_WB_DONE = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_HOST = 1'b0,
        GNT_WB   = 1'b1
    } arb_gnt_e;

    localparam int TMO_CNT_W = 8;

    // Wide enough for any supported DATA_WIDTH; sliced at the use site.
    localparam logic [127:0] RD_ERR_WORD = '1;

endpackage

// File: rtl/mirror_arb_rr2.sv
// Two-way round-robin picker; last_grant is remembered only when i_upd is high.
module mirror_arb_rr2
    import mirror_arb_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     i_req_host,
    input  logic     i_req_wb,
    input  logic     i_upd,
    output arb_gnt_e o_gnt,
    output logic     o_vld
);

    arb_gnt_e r_last;

    always_comb begin
        o_vld = i_req_host | i_req_wb;
        if (i_req_host && i_req_wb)
            o_gnt = (r_last == GNT_WB) ? GNT_HOST : GNT_WB;
        else if (i_req_wb)
            o_gnt = GNT_WB;
        else
            o_gnt = GNT_HOST;
    end

    // Reset to WB so the host wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_last <= GNT_WB;
        else if (i_upd && o_vld)
            r_last <= o_gnt;
    end

endmodule

// File: rtl/mirror_bus_arbiter.sv
// Arbitrates the host bus and the TWI Wishbone master onto one register port.
// Optional register-ack watchdog: define MIRROR_ARB_TIMEOUT_EN.
module mirror_bus_arbiter
    import mirror_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    host_wren_i,
    input  logic                    host_rden_i,
    input  logic [ADDR_WIDTH-1:0]   host_addr_i,
    input  logic [DATA_WIDTH-1:0]   host_data_i,
    output logic [DATA_WIDTH-1:0]   host_data_o,
    output logic                    host_ack_o,
    output logic                    host_overrun_o,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    reg_wr_o,
    output logic                    reg_rd_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_be_o,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_ack_i
);

    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_e            r_state;
    arb_gnt_e              r_gnt;
    logic                  r_hpend, r_hwe;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [DATA_WIDTH-1:0] r_hdata;
    logic                  r_strobe, r_we, r_abort, r_zack;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_host_rdata, r_wb_rdata;

    logic                  w_host_pulse, w_host_done, w_host_req, w_host_we;
    logic [ADDR_WIDTH-1:0] w_host_addr;
    logic [DATA_WIDTH-1:0] w_host_wdat;
    logic                  w_wb_req, w_wb_oor, w_idle, w_vld, w_ack_ok;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    arb_gnt_e              w_gnt;
    logic                  w_unused;

    assign w_host_pulse = host_wren_i | host_rden_i;
    assign w_host_done  = (r_state == ST_RESP) && (r_gnt == GNT_HOST);
    assign w_host_req   = r_hpend | w_host_pulse;
    // A fresh pulse is serviced straight from the bus; write beats read.
    assign w_host_we    = r_hpend ? r_hwe   : host_wren_i;
    assign w_host_addr  = r_hpend ? r_haddr : host_addr_i;
    assign w_host_wdat  = r_hpend ? r_hdata : host_data_i;

    assign w_wb_req  = wb_cyc_i & wb_stb_i;
    assign w_wb_oor  = |wb_adr_i[WB_ADDR_WIDTH-1:ADDR_WIDTH+2];
    assign w_wb_addr = wb_adr_i[ADDR_WIDTH+1:2];
    assign w_idle    = (r_state == ST_IDLE);
    assign w_ack_ok  = !r_strobe && reg_ack_i;
    assign w_unused  = ^{wb_adr_i[1:0], TIMEOUT_CYCLES[0]};

    mirror_arb_rr2 u_rr2 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_req_host (w_host_req),
        .i_req_wb   (w_wb_req),
        .i_upd      (w_idle),
        .o_gnt      (w_gnt),
        .o_vld      (w_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hpend <= 1'b0;
            r_hwe   <= 1'b0;
            r_haddr <= '0;
            r_hdata <= '0;
        end else if (w_host_pulse && (!r_hpend || w_host_done)) begin
            r_hpend <= 1'b1;
            r_hwe   <= host_wren_i;
            r_haddr <= host_addr_i;
            r_hdata <= host_data_i;
        end else if (w_host_done) begin
            r_hpend <= 1'b0;
        end
    end

`ifdef MIRROR_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_cnt;
    logic                 w_tmo;
    assign w_tmo = (r_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || w_idle)
            r_cnt <= '0;
        else if (r_state == ST_ACCESS)
            r_cnt <= r_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_gnt        <= GNT_HOST;
            r_strobe     <= 1'b0;
            r_we         <= 1'b0;
            r_abort      <= 1'b0;
            r_zack       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_host_rdata <= '0;
            r_wb_rdata   <= '0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vld) begin
                        r_gnt   <= w_gnt;
                        r_abort <= 1'b0;
                        r_zack  <= 1'b0;
                        if (w_gnt == GNT_HOST) begin
                            r_state  <= ST_ACCESS;
                            r_strobe <= 1'b1;
                            r_we     <= w_host_we;
                            r_addr   <= w_host_addr;
                            r_wdata  <= w_host_wdat;
                            r_be     <= '1;
                        end else if (w_wb_oor) begin
                            r_state <= ST_WB_ERR;
                        end else if (wb_we_i && (wb_sel_i == '0)) begin
                            r_state    <= ST_WB_DONE;
                            r_zack     <= 1'b1;
                            r_wb_rdata <= '0;
                        end else begin
                            r_state  <= ST_ACCESS;
                            r_strobe <= 1'b1;
                            r_we     <= wb_we_i;
                            r_addr   <= w_wb_addr;
                            r_wdata  <= wb_dat_i;
                            r_be     <= wb_sel_i;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_gnt == GNT_WB && !wb_cyc_i)
                        r_abort <= 1'b1;
                    if (w_ack_ok) begin
                        r_state <= ST_RESP;
                        if (r_gnt == GNT_HOST)
                            r_host_rdata <= r_we ? '0 : reg_rdata_i;
                        else
                            r_wb_rdata   <= r_we ? '0 : reg_rdata_i;
                    end
`ifdef MIRROR_ARB_TIMEOUT_EN
                    else if (w_tmo) begin
                        if (r_gnt == GNT_HOST) begin
                            r_state      <= ST_RESP;
                            r_host_rdata <= RD_ERR_WORD[DATA_WIDTH-1:0];
                        end else begin
                            r_state <= ST_WB_ERR;
                        end
                    end
`endif
                end
                ST_RESP:    r_state <= (r_gnt == GNT_HOST) ? ST_IDLE : ST_WB_DONE;
                ST_WB_ERR:  r_state <= ST_WB_DONE;
                ST_WB_DONE: begin
                    r_state <= ST_IDLE;
                    r_zack  <= 1'b0;
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_ack_o     = w_host_done;
    assign host_data_o    = r_host_rdata;
    assign host_overrun_o = w_host_pulse & r_hpend & ~w_host_done;
    assign wb_dat_o       = r_wb_rdata;
    // An aborted WB cycle still finishes on the register port but gets no response.
    assign wb_ack_o       = ((r_state == ST_RESP) && (r_gnt == GNT_WB) && !r_abort)
                          || ((r_state == ST_WB_DONE) && r_zack);
    assign wb_err_o       = (r_state == ST_WB_ERR) && !r_abort;
    assign reg_wr_o       = r_strobe & r_we;
    assign reg_rd_o       = r_strobe & ~r_we;
    assign reg_addr_o     = r_addr;
    assign reg_wdata_o    = r_wdata;
    assign reg_be_o       = r_be;

endmodule

// File: tb/tb_mirror_bus_arbiter.sv
// Directed vector bench for mirror_bus_arbiter with a byte-enabled register-file model.
module tb_mirror_bus_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int WAW = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_i;
    logic host_wren_i, host_rden_i;
    logic [AW-1:0] host_addr_i;
    logic [DW-1:0] host_data_i, host_data_o;
    logic host_ack_o, host_overrun_o;
    logic wb_cyc_i, wb_stb_i, wb_we_i;
    logic [WAW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i, wb_dat_o;
    logic [3:0] wb_sel_i;
    logic wb_ack_o, wb_err_o;
    logic reg_wr_o, reg_rd_o;
    logic [AW-1:0] reg_addr_o;
    logic [DW-1:0] reg_wdata_o, reg_rdata_i;
    logic [3:0] reg_be_o;
    logic reg_ack_i;
    logic ack_en, mem_clr;

    always #5 clk = ~clk;

    mirror_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WB_ADDR_WIDTH(WAW),
                         .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .host_wren_i(host_wren_i), .host_rden_i(host_rden_i), .host_addr_i(host_addr_i),
        .host_data_i(host_data_i), .host_data_o(host_data_o), .host_ack_o(host_ack_o),
        .host_overrun_o(host_overrun_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o), .reg_rdata_i(reg_rdata_i),
        .reg_ack_i(reg_ack_i)
    );

    // Register file: acks every strobe on the following cycle, independent of rst_i.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        reg_ack_i <= 1'b0;
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (ack_en && (reg_wr_o || reg_rd_o)) begin
            reg_ack_i   <= 1'b1;
            reg_rdata_i <= mem[reg_addr_o];
            if (reg_wr_o)
                for (int b = 0; b < 4; b++)
                    if (reg_be_o[b]) mem[reg_addr_o][8*b +: 8] <= reg_wdata_o[8*b +: 8];
        end
    end

    int n_hack, n_wack, n_werr, n_ovr, n_strb;
    logic [AW-1:0] log_addr [256];
    logic [3:0]    log_be   [256];
    always @(negedge clk) begin
        if (host_ack_o)     n_hack <= n_hack + 1;
        if (wb_ack_o)       n_wack <= n_wack + 1;
        if (wb_err_o)       n_werr <= n_werr + 1;
        if (host_overrun_o) n_ovr  <= n_ovr + 1;
        if (reg_wr_o || reg_rd_o) begin
            log_addr[n_strb[7:0]] <= reg_addr_o;
            log_be[n_strb[7:0]]   <= reg_be_o;
            n_strb <= n_strb + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return {host_data_o, host_ack_o, host_overrun_o, wb_dat_o, wb_ack_o, wb_err_o,
                reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o, reg_be_o};
    endfunction

    task automatic idle_inputs();
        host_wren_i = 0; host_rden_i = 0; host_addr_i = '0; host_data_i = '0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        idle_inputs();
        tick();
        tick();
        rst_i = 0;
    endtask

    typedef struct {
        bit          is_wb;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          lat;
        bit          err;
        bit          access;
        logic [3:0]  raddr;
        logic [3:0]  be;
        logic [31:0] rdat;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int s0, lat;
        bit got, rerr;
        logic [31:0] rdat;
        s0 = n_strb; lat = 0; got = 0; rerr = 0; rdat = '0;
        if (v.is_wb) begin
            wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = v.we; wb_adr_i = v.adr;
            wb_dat_i = v.wdat; wb_sel_i = v.sel;
        end else begin
            host_wren_i = v.we; host_rden_i = !v.we;
            host_addr_i = v.adr[AW-1:0]; host_data_i = v.wdat;
        end
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            host_wren_i = 0; host_rden_i = 0;
            if (c == 1)
                chk({tag, " strobe@1"}, {reg_wr_o, reg_rd_o},
                    v.access ? (v.we ? 2'b10 : 2'b01) : 2'b00);
            if (host_ack_o || wb_ack_o || wb_err_o) begin
                got = 1; lat = c; rerr = wb_err_o;
                rdat = v.is_wb ? wb_dat_o : host_data_o;
            end
        end
        tick();
        wb_cyc_i = 0; wb_stb_i = 0;
        tick();
        tick();
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " err"}, rerr, v.err);
        if (!v.err) chk({tag, " rdata"}, rdat, v.rdat);
        chk({tag, " strobes"}, n_strb - s0, v.access ? 1 : 0);
        if (v.access) begin
            chk({tag, " addr"}, log_addr[s0[7:0]], v.raddr);
            chk({tag, " be"}, log_be[s0[7:0]], v.be);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int s0, h0, w0, o0, k;
        ack_en = 1; mem_clr = 1;
        do_reset();
        mem_clr = 0;
        chk("reset outputs", all_outs(), '0);

        //           wb we adr           wdat          sel  lat err acc ra   be    rdat
        tbl.push_back('{0, 1, 32'h3,        32'hDEADBEEF, 4'h0, 3, 0, 1, 4'h3, 4'hF, 32'h0});
        tbl.push_back('{0, 0, 32'h3,        32'h0,        4'h0, 3, 0, 1, 4'h3, 4'hF, 32'hDEADBEEF});
        tbl.push_back('{1, 1, 32'h3C,       32'h12345678, 4'h3, 3, 0, 1, 4'hF, 4'h3, 32'h0});
        tbl.push_back('{1, 0, 32'h3C,       32'h0,        4'hF, 3, 0, 1, 4'hF, 4'hF, 32'h00005678});
        tbl.push_back('{1, 0, 32'h40,       32'h0,        4'hF, 1, 1, 0, 4'h0, 4'h0, 32'h0});
        tbl.push_back('{1, 1, 32'h08,       32'h77,       4'h0, 1, 0, 0, 4'h0, 4'h0, 32'h0});
        tbl.push_back('{1, 0, 32'h0E,       32'h0,        4'hF, 3, 0, 1, 4'h3, 4'hF, 32'hDEADBEEF});
        tbl.push_back('{0, 1, 32'h0,        32'hA5A5A5A5, 4'h0, 3, 0, 1, 4'h0, 4'hF, 32'h0});
        tbl.push_back('{1, 0, 32'h00,       32'h0,        4'h5, 3, 0, 1, 4'h0, 4'h5, 32'hA5A5A5A5});
        tbl.push_back('{1, 0, 32'h80000000, 32'h0,        4'hF, 1, 1, 0, 4'h0, 4'h0, 32'h0});
        tbl.push_back('{1, 0, 32'h08,       32'h0,        4'hF, 3, 0, 1, 4'h2, 4'hF, 32'h0});
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // WB strobe held through WB_DONE must not trigger a second write.
        s0 = n_strb; w0 = n_wack; k = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h4; wb_dat_i = 32'h11; wb_sel_i = 4'hF;
        for (int c = 0; c < 40 && !wb_ack_o; c++) tick();
        tick();
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("stb hold strobes", n_strb - s0, 1);
        chk("stb hold acks", n_wack - w0, 1);

        // Ties alternate, host first after reset.
        do_reset();
        s0 = n_strb;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h8; wb_sel_i = 4'hF;
        host_rden_i = 1; host_addr_i = 4'd1;
        for (int c = 0; c < 300 && (n_strb - s0) < 8; c++) begin
            tick();
            host_rden_i = host_ack_o;
        end
        idle_inputs();
        repeat (12) tick();
        chk("tie count", (n_strb - s0) >= 8, 1'b1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tie %0d", i), log_addr[(s0 + i) & 255], (i % 2 == 0) ? 4'd1 : 4'd2);

        // Second host pulse while pending is dropped.
        do_reset();
        h0 = n_hack; o0 = n_ovr;
        host_wren_i = 1; host_addr_i = 4'd5; host_data_i = 32'h55;
        tick();
        host_wren_i = 1; host_data_i = 32'h66;
        #1;
        chk("overrun pulse", host_overrun_o, 1'b1);
        tick();
        idle_inputs();
        repeat (8) tick();
        chk("overrun acks", n_hack - h0, 1);
        chk("overrun count", n_ovr - o0, 1);
        run_vec('{0, 0, 32'h5, 32'h0, 4'h0, 3, 0, 1, 4'h5, 4'hF, 32'h55}, "ovr rd");

        // Reset in ACCESS: outputs clear, late ack ignored.
        h0 = n_hack; s0 = n_strb;
        host_rden_i = 1; host_addr_i = 4'd3;
        tick();
        chk("rst strobe", reg_rd_o, 1'b1);
        host_rden_i = 0; rst_i = 1;
        tick();
        chk("rst outputs", all_outs(), '0);
        rst_i = 0;
        repeat (6) tick();
        chk("rst no ack", n_hack - h0, 0);
        chk("rst strobes", n_strb - s0, 1);

        // WB abort: access completes, no ack.
        w0 = n_wack; s0 = n_strb;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'hC; wb_sel_i = 4'hF;
        tick();
        wb_cyc_i = 0; wb_stb_i = 0;
        repeat (8) tick();
        chk("abort no ack", n_wack - w0, 0);
        chk("abort strobes", n_strb - s0, 1);

`ifdef MIRROR_ARB_TIMEOUT_EN
        ack_en = 0;
        do_reset();
        run_vec('{0, 0, 32'h2, 32'h0, 4'h0, TMO + 1, 0, 1, 4'h2, 4'hF, 32'hFFFFFFFF}, "tmo host");
        run_vec('{1, 0, 32'h8, 32'h0, 4'hF, TMO + 1, 1, 1, 4'h2, 4'hF, 32'h0}, "tmo wb");
        ack_en = 1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mirror_bus_arbiter.md
Name: mirror_bus_arbiter

Overview:
- Shares one word-wide register port between two requesters:
  - the local host bus (single-cycle wren/rden pulses);
  - the Wishbone master driven by the TWI slave.
- Sits between those two masters and the register-file mirror.
- Sequences one access at a time with round-robin fairness, address-range checking and per-requester response signalling.

Parameters:
ADDR_WIDTH, 4, register word-address width on host bus and register port
DATA_WIDTH, 32, data width on all ports
WB_ADDR_WIDTH, 32, Wishbone byte-address width
TIMEOUT_CYCLES, 255, register-port ack watchdog limit (used only with MIRROR_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
host_wren_i  in  1  host write request pulse
host_rden_i  in  1  host read request pulse
host_addr_i  in  ADDR_WIDTH  host word address
host_data_i  in  DATA_WIDTH  host write data
host_data_o  out  DATA_WIDTH  host read data, valid with host_ack_o
host_ack_o  out  1  host completion pulse
host_overrun_o  out  1  pulse: host request dropped while one was pending
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle/strobe/write-enable
wb_adr_i  in  WB_ADDR_WIDTH  Wishbone byte address
wb_dat_i  in  DATA_WIDTH  Wishbone write data
wb_sel_i  in  DATA_WIDTH/8  byte selects
wb_dat_o  out  DATA_WIDTH  Wishbone read data
wb_ack_o  out  1  Wishbone ack pulse
wb_err_o  out  1  Wishbone error pulse
reg_wr_o  out  1  register write strobe, 1 cycle
reg_rd_o  out  1  register read strobe, 1 cycle
reg_addr_o  out  ADDR_WIDTH  register word address
reg_wdata_o  out  DATA_WIDTH  register write data
reg_be_o  out  DATA_WIDTH/8  byte enables
reg_rdata_i  in  DATA_WIDTH  register read data, valid with reg_ack_i
reg_ack_i  in  1  register completion

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - all outputs 0;
  - state IDLE, host pending latch clear;
  - last_grant = WB, so the host wins the first tie.
- Host requests:
  - A wren or rden pulse latches addr, data and direction into the pending register.
  - If wren and rden arrive in the same cycle, the write wins.
  - A pulse while a request is already pending is dropped; host_overrun_o pulses in the same cycle.
- Wishbone request: wb_cyc_i & wb_stb_i sampled in IDLE.
- Wishbone decode:
  - word address = wb_adr_i[ADDR_WIDTH+1:2]; bits [1:0] ignored;
  - any set bit above ADDR_WIDTH+1 is out of range.
- States:
  - IDLE: pick a requester. If both are pending, grant the one that was not last_grant; update last_grant.
    - Out-of-range WB request -> WB_ERR.
    - WB write with wb_sel_i == 0 -> WB_DONE with ack and no register access.
    - Otherwise -> ACCESS.
  - ACCESS:
    - Entry cycle: drive reg_wr_o or reg_rd_o for exactly 1 cycle, together with addr, wdata and be.
    - reg_be_o = wb_sel_i for WB grants, all ones for host grants.
    - reg_ack_i is sampled from the cycle after the strobe. An ack coincident with the strobe is ignored.
    - On ack: capture reg_rdata_i -> RESP.
  - RESP: 1-cycle pulse of host_ack_o or wb_ack_o, with data_o valid.
    - Host read data is held until the next host ack.
    - Write responses return 0.
    - Host pending latch clears here. A host pulse in this cycle is accepted.
    - Host grant -> IDLE. WB grant -> WB_DONE.
  - WB_ERR: 1-cycle wb_err_o -> WB_DONE.
  - WB_DONE: 1 cycle that ignores wb_stb_i, so the same transfer is never serviced twice -> IDLE.
- Minimum latency: request at cycle 0, strobe at 1, reg_ack at 2, response pulse at 3.
- WB abort: wb_cyc_i low during ACCESS. The register access still completes; wb_ack_o is suppressed.
- Reset mid-ACCESS: return to IDLE with no response. A late reg_ack_i is ignored in IDLE.

Optional Feature:
MIRROR_ARB_TIMEOUT_EN
- Defined:
  - An 8+ bit counter runs in ACCESS.
  - At TIMEOUT_CYCLES cycles without reg_ack_i, abandon the access.
  - Host grant: host_ack_o with host_data_o = all ones.
  - WB grant: wb_err_o, then WB_DONE.
  - The counter clears on entering ACCESS.
- Undefined: ACCESS waits indefinitely; no counter logic.

Decomposition:
- Package mirror_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP, WB_ERR, WB_DONE);
  - grant enum (GNT_HOST, GNT_WB);
  - timeout counter width constant;
  - all-ones read-error constant.
- One sub-module: mirror_arb_rr2. It is a 2-way round-robin picker with registered last_grant, and takes an update enable.

Test Plan:
- Host write addr 3, data 0xDEADBEEF -> reg_wr_o at cycle 1, reg_be_o = 0xF, then host_ack_o one cycle after reg_ack_i. A follow-up host read of addr 3 returns 0xDEADBEEF on host_data_o.
- Host rden and WB read both asserted in one cycle after reset -> host serviced first. Next tie goes to WB; strict alternation over 8 ties.
- WB read at byte address 0x40 (ADDR_WIDTH = 4) -> wb_err_o pulse, no reg_rd_o. Byte address 0x3C -> reg_addr_o = 0xF.
- WB write with sel = 0x3 -> reg_be_o = 0x3. wb_stb_i held high one extra cycle after ack -> exactly one reg_wr_o.
- Second host pulse while the first is pending -> host_overrun_o pulse, only one host_ack_o. rst_i during ACCESS -> all outputs 0 the next cycle, no ack.
- Timeout build, reg_ack_i never asserted, TIMEOUT_CYCLES = 16:
  - host read -> host_ack_o with data 0xFFFFFFFF, 16 cycles after the strobe;
  - WB read -> wb_err_o.
